// File: rtl/delaybuf_ctrl.sv
// delaybuf_ctrl: address/handshake sequencer for the circular delay RAM of
// one SDF stage. The RAM is external, read-first, with 1-cycle read latency.
// It fills depth_p samples, then runs write+read in lockstep to give a
// depth_p-sample delay, and drains the stored samples on flush.
// Optional input stall counter: define DELAYBUF_CTRL_STATS_EN.
module delaybuf_ctrl #(
  parameter int depth_p = 16,
  parameter int width_p = $clog2(depth_p)
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               valid_i,
  output logic               ready_o,
  output logic               valid_o,
  input  logic               ready_i,
  input  logic               flush_i,
  output logic               mem_we_o,
  output logic [width_p-1:0] mem_waddr_o,
  output logic               mem_re_o,
  output logic [width_p-1:0] mem_raddr_o,
  output logic [width_p:0]   fill_o,
  output logic               bf_sel_o,
  output logic [1:0]         state_o,
  output logic [15:0]        stall_cnt_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2, DRAIN = 2'd3} state_t;

  localparam logic [width_p-1:0] LAST_PTR = width_p'(depth_p - 1);
  localparam logic [width_p:0]   FULL     = (width_p + 1)'(depth_p);

  state_t             state, state_nxt;
  logic [width_p-1:0] wr_ptr, rd_ptr;
  logic [width_p:0]   fill, fill_nxt;
  logic               valid_q, bf_sel;
  logic               acc, out_adv, rd_issue;

  // Handshake, RAM strobes and next-state/fill decisions.
  always_comb begin
    state_nxt = state;
    fill_nxt  = fill;
    out_adv   = !valid_q || ready_i;
    ready_o   = 1'b0;
    rd_issue  = 1'b0;
    unique case (state)
      IDLE, FILL: ready_o = 1'b1;
      RUN:        ready_o = out_adv;
      default:    ready_o = 1'b0;
    endcase
    if (flush_i || !reset_ni) ready_o = 1'b0;
    acc = valid_i && ready_o;
    unique case (state)
      IDLE: begin
        if (acc) begin
          state_nxt = FILL;
          fill_nxt  = (width_p + 1)'(1);
        end
      end
      FILL: begin
        if (flush_i) begin
          state_nxt = (fill != '0) ? DRAIN : IDLE;
        end else if (acc) begin
          fill_nxt = fill + 1'b1;
          if (fill + 1'b1 == FULL) state_nxt = RUN;
        end
      end
      RUN: begin
        // Read-first RAM with rd_ptr==wr_ptr returns the sample written
        // depth_p accepts ago while the new one lands in the same slot.
        rd_issue = acc;
        if (flush_i) state_nxt = DRAIN;
      end
      default: begin
        rd_issue = out_adv && (fill != '0);
        if (rd_issue)
          fill_nxt = fill - 1'b1;
        else if (fill == '0 && valid_q && ready_i)
          state_nxt = IDLE;
      end
    endcase
    if (!reset_ni) rd_issue = 1'b0;
  end

  // State, pointers, fill, output valid and butterfly toggle.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state   <= IDLE;
      fill    <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      valid_q <= 1'b0;
      bf_sel  <= 1'b0;
    end else begin
      state <= state_nxt;
      fill  <= fill_nxt;
      if (acc) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
        if (wr_ptr == LAST_PTR) bf_sel <= !bf_sel;
      end
      if (rd_issue) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      if (rd_issue)                valid_q <= 1'b1;
      else if (valid_q && ready_i) valid_q <= 1'b0;
    end
  end

`ifdef DELAYBUF_CTRL_STATS_EN
  logic [15:0] stall_cnt;
  // Saturating count of cycles where upstream offered a sample and was refused.
  always_ff @(posedge clk_i) begin
    if (!reset_ni)
      stall_cnt <= '0;
    else if (valid_i && !ready_o && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
  assign stall_cnt_o = stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

  assign valid_o     = valid_q;
  assign mem_we_o    = acc;
  assign mem_waddr_o = wr_ptr;
  assign mem_re_o    = rd_issue;
  assign mem_raddr_o = rd_ptr;
  assign fill_o      = fill;
  assign bf_sel_o    = bf_sel;
  assign state_o     = state;

endmodule

// File: tb/tb_delaybuf_ctrl.sv
// Bench for delaybuf_ctrl (depth 4): read-first RAM model driven by the DUT
// strobes, queue-based reference of the delay line checked every cycle, and
// directed scenarios with literal expectations.
module tb_delaybuf_ctrl;
  localparam int D = 4;

  logic        clk_i = 1'b0;
  logic        reset_ni, valid_i, ready_i, flush_i;
  logic        ready_o, valid_o, mem_we_o, mem_re_o, bf_sel_o;
  logic [1:0]  mem_waddr_o, mem_raddr_o, state_o;
  logic [2:0]  fill_o;
  logic [15:0] stall_cnt_o;
  logic [15:0] din, rdata;
  logic [15:0] ram [D];

  int checks = 0;
  int errors = 0;

  delaybuf_ctrl #(.depth_p(D)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .valid_i(valid_i), .ready_o(ready_o),
    .valid_o(valid_o), .ready_i(ready_i), .flush_i(flush_i),
    .mem_we_o(mem_we_o), .mem_waddr_o(mem_waddr_o), .mem_re_o(mem_re_o),
    .mem_raddr_o(mem_raddr_o), .fill_o(fill_o), .bf_sel_o(bf_sel_o),
    .state_o(state_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // External read-first RAM; read data holds when no read is issued.
  always @(posedge clk_i) begin
    if (mem_re_o) rdata <= ram[mem_raddr_o];
    if (mem_we_o) ram[mem_waddr_o] <= din;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: the delay line is a queue of stored samples; fill is its size,
  // pointers are total writes/reads modulo D, bf_sel is parity of writes/D.
  int          q[$];
  int          nwr = 0, nrd = 0, m_out = 0;
  bit          m_valid = 0, drn = 0;
  logic [15:0] m_stall = 0;

  always @(negedge clk_i) begin
    int sz, mode;
    bit adv, e_rdy, e_acc, e_rd, hs;
    sz    = q.size();
    mode  = drn ? 3 : (sz == 0 ? 0 : (sz < D ? 1 : 2));
    adv   = !m_valid || ready_i;
    e_rdy = reset_ni && !flush_i && (mode < 2 || (mode == 2 && adv));
    e_acc = valid_i && e_rdy;
    e_rd  = reset_ni && ((mode == 2 && e_acc) || (mode == 3 && adv && sz > 0));
    hs    = m_valid && ready_i;
    chk("ready_o", ready_o, e_rdy);
    chk("valid_o", valid_o, m_valid);
    chk("mem_we_o", mem_we_o, e_acc);
    chk("mem_re_o", mem_re_o, e_rd);
    chk("fill_o", fill_o, sz);
    chk("state_o", state_o, mode);
    chk("bf_sel_o", bf_sel_o, (nwr / D) % 2);
    chk("stall_cnt_o", stall_cnt_o, m_stall);
    if (e_acc) chk("mem_waddr_o", mem_waddr_o, nwr % D);
    if (e_rd)  chk("mem_raddr_o", mem_raddr_o, nrd % D);
    if (hs)    chk("out_data", rdata, m_out);
    if (!reset_ni) begin
      q.delete(); nwr = 0; nrd = 0; m_valid = 0; drn = 0; m_stall = 0;
    end else begin
`ifdef DELAYBUF_CTRL_STATS_EN
      if (valid_i && !e_rdy && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
`endif
      if (drn && sz == 0 && hs) drn = 0;
      else if (!drn && flush_i && mode != 0) drn = 1;
      if (e_rd) begin m_out = q.pop_front(); nrd++; end
      if (e_acc) begin q.push_back(int'(din)); nwr++; end
      if (e_rd) m_valid = 1;
      else if (hs) m_valid = 0;
    end
  end

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (state_o != 2'd0 && n < 30) begin step(); n++; end
    chk(nm, state_o, 0);
  endtask

  initial begin
    reset_ni = 0; valid_i = 0; ready_i = 1; flush_i = 0; din = 0;
    step(); step();
    #2 chk("rst_fill", fill_o, 0);
    chk("rst_state", state_o, 0);
    chk("rst_ready", ready_o, 0);
    step();
    reset_ni = 1;

    // Fill: addresses 0..3, IDLE then FILL, no output yet.
    for (int k = 0; k < 4; k++) begin
      valid_i = 1; din = 16'(k);
      #2 chk("fill_waddr", mem_waddr_o, k);
      chk("fill_state", state_o, k == 0 ? 0 : 1);
      chk("fill_cnt", fill_o, k);
      step();
    end

    // Steady run: samples 4..11, output delayed by 4.
    for (int k = 4; k < 12; k++) begin
      din = 16'(k);
      #2;
      if (k == 4) begin
        chk("run_state", state_o, 2); chk("run_fill", fill_o, 4);
        chk("run_valid0", valid_o, 0); chk("bf_after3", bf_sel_o, 1);
      end
      if (k == 5) begin chk("first_valid", valid_o, 1); chk("first_out", rdata, 0); end
      if (k == 8) chk("bf_after7", bf_sel_o, 0);
      step();
    end
    #2 chk("bf_after11", bf_sel_o, 1);

    // Backpressure: 3 cycles of ready_i=0 with sample 7 pending.
    ready_i = 0; din = 16'd12;
    for (int k = 0; k < 3; k++) begin
      #2 chk("bp_ready", ready_o, 0);
      chk("bp_we", mem_we_o, 0);
      chk("bp_held", rdata, 7);
      step();
    end
`ifdef DELAYBUF_CTRL_STATS_EN
    #2 chk("bp_stall", stall_cnt_o, 3);
`else
    #2 chk("bp_stall", stall_cnt_o, 0);
`endif
    ready_i = 1;
    for (int k = 12; k < 15; k++) begin din = 16'(k); step(); end

    // Flush from RUN: input refused, then 4 reads.
    flush_i = 1; din = 16'd99;
    #2 chk("flush_ready", ready_o, 0);
    step();
    flush_i = 0; valid_i = 0;
    #2 chk("drain_state", state_o, 3);
    chk("drain_fill", fill_o, 4);
    wait_idle("drain_idle");

    // Flush while idle does nothing.
    flush_i = 1; valid_i = 1; din = 16'd55;
    step();
    flush_i = 0; valid_i = 0;
    #2 chk("idle_flush_state", state_o, 0);
    chk("idle_flush_fill", fill_o, 0);

    // Flush in FILL at fill=2, with a stall cycle at drain start.
    valid_i = 1; din = 16'd20; step();
    din = 16'd21; step();
    valid_i = 0; flush_i = 1;
    #2 chk("fill2_cnt", fill_o, 2);
    step();
    flush_i = 0; ready_i = 0;
    #2 chk("fill2_drain", state_o, 3);
    step();
    ready_i = 1;
    wait_idle("fill2_idle");

    // Reset in the middle of RUN.
    valid_i = 1;
    for (int k = 30; k < 36; k++) begin din = 16'(k); step(); end
    reset_ni = 0; din = 16'd36;
    step();
    reset_ni = 1; valid_i = 0;
    #2 chk("mrst_fill", fill_o, 0);
    chk("mrst_state", state_o, 0);
    chk("mrst_valid", valid_o, 0);
    chk("mrst_bf", bf_sel_o, 0);
    chk("mrst_stall", stall_cnt_o, 0);
    valid_i = 1; din = 16'd40; step();
    din = 16'd41; step();
    valid_i = 0; step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
